// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: fetch port (i_*), data port (d_*) and memory port (mem_*).
// The slave modport is the arbiter's view. The master modport is the CPU/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_ack;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_ack;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (I) and data access (D), with D priority.
// Define STARVE_GUARD_EN to let I win after STARVE_MAX consecutive D grants made while I was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state_reg;
  logic              i_ack_reg;
  logic              d_ack_reg;
  logic [DATA_W-1:0] i_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [STRB_W-1:0] mem_wstrb_reg;

  logic ack_cycle;
  logic i_elig;
  logic d_elig;
  logic starve;
  logic grant_i;
  logic grant_d;

  // The ack cycle is a turnaround: no request is evaluated in it. A requester that
  // still holds its request then competes on equal terms in the following IDLE cycle.
  assign ack_cycle = i_ack_reg | d_ack_reg;
  assign i_elig    = bus.i_req & ~ack_cycle;
  assign d_elig    = bus.d_req & ~ack_cycle;

`ifdef STARVE_GUARD_EN
  logic [3:0] streak_reg;

  assign starve = (streak_reg == 4'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      streak_reg <= 4'd0;
    end else if (grant_i) begin
      streak_reg <= 4'd0;
    end else if (grant_d) begin
      if (!i_elig)
        streak_reg <= 4'd0;
      else if (!starve)
        streak_reg <= streak_reg + 4'd1;
    end
  end
`else
  // STARVE_MAX has no effect in this build.
  assign starve = 1'b0 & (STARVE_MAX != 0);
`endif

  assign grant_i = (state_reg == IDLE) & i_elig & (~d_elig | starve);
  assign grant_d = (state_reg == IDLE) & d_elig & ~grant_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      i_ack_reg     <= 1'b0;
      d_ack_reg     <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
    end else begin
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= bus.d_we;
            mem_addr_reg  <= bus.d_addr;
            mem_wdata_reg <= bus.d_wdata;
            mem_wstrb_reg <= bus.d_we ? bus.d_wstrb : '0;
            state_reg     <= BUSY_D;
          end else if (grant_i) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= bus.i_addr;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            state_reg     <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (bus.mem_ready) begin
            i_rdata_reg <= bus.mem_rdata;
            i_ack_reg   <= 1'b1;
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        BUSY_D: begin
          if (bus.mem_ready) begin
            d_rdata_reg <= bus.mem_rdata;
            d_ack_reg   <= 1'b1;
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_ack     = i_ack_reg;
  assign bus.i_rdata   = i_rdata_reg;
  assign bus.d_ack     = d_ack_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_wstrb = mem_wstrb_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with programmable latency plus a grant/ack scoreboard.
// Build with STARVE_GUARD_EN defined or undefined; the contention expectations follow the macro.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t pend_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   ack_cnt   = 0;
  int   i_ack_cnt = 0;
  int   mem_lat   = 1;
  bit   mem_auto  = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] addr);
    if (addr == 32'h100) return 32'h2402_0005;
    return {~addr[15:0], addr[15:0]};
  endfunction

  task automatic sb_push(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    txn_t t;
    t.is_d  = is_d;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.wstrb = we ? wstrb : 4'h0;
    t.rdata = rd_fn(addr);
    exp_q.push_back(t);
  endtask

  // Memory model: mem_ready pulses in the mem_lat-th cycle of mem_req.
  initial begin
    int cnt;
    cnt           = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_auto && bus.mem_req) begin
        if (cnt >= mem_lat - 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd_fn(bus.mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: compares each new grant against exp_q and each ack against the granted entry.
  initial begin
    txn_t        e;
    txn_t        g;
    bit          prev_req;
    logic [31:0] got;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && !prev_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL grant_unexpected got addr=%h we=%0b exp=none", bus.mem_addr, bus.mem_we);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || bus.mem_wstrb !== e.wstrb ||
              (e.we && bus.mem_wdata !== e.wdata)) begin
            failures++;
            $display("FAIL grant got we=%0b addr=%h wdata=%h wstrb=%h exp we=%0b addr=%h wdata=%h wstrb=%h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, e.we, e.addr, e.wdata, e.wstrb);
          end
          pend_q.push_back(e);
          g.we = bus.mem_we; g.addr = bus.mem_addr; g.wdata = bus.mem_wdata; g.wstrb = bus.mem_wstrb;
        end
      end else if (bus.mem_req === 1'b1 && prev_req) begin
        checks++;
        if (bus.mem_we !== g.we || bus.mem_addr !== g.addr || bus.mem_wdata !== g.wdata || bus.mem_wstrb !== g.wstrb) begin
          failures++;
          $display("FAIL mem_stable got addr=%h wdata=%h wstrb=%h exp addr=%h wdata=%h wstrb=%h",
                   bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, g.addr, g.wdata, g.wstrb);
        end
      end
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        ack_cnt++;
        if (bus.i_ack === 1'b1) i_ack_cnt++;
        checks++;
        if (pend_q.size() == 0) begin
          failures++;
          $display("FAIL ack_unexpected got i_ack=%0b d_ack=%0b exp no ack", bus.i_ack, bus.d_ack);
        end else begin
          e   = pend_q.pop_front();
          got = bus.d_ack ? bus.d_rdata : bus.i_rdata;
          if ((bus.i_ack & bus.d_ack) !== 1'b0 || bus.d_ack !== e.is_d || (!e.we && got !== e.rdata)) begin
            failures++;
            $display("FAIL ack got i_ack=%0b d_ack=%0b rdata=%h exp %s rdata=%h",
                     bus.i_ack, bus.d_ack, got, e.is_d ? "d_ack" : "i_ack", e.rdata);
          end
          $display("txn %s addr=%h we=%0b rdata=%h", e.is_d ? "D" : "I", e.addr, e.we, got);
        end
      end
      prev_req = (bus.mem_req === 1'b1);
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40;
    bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack} !== 4'b0 || bus.mem_addr !== 32'h0 ||
          bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got mem_req=%b mem_addr=%h i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h exp all 0",
                 k, bus.mem_req, bus.mem_addr, bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata);
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_fetch();
    mem_lat = 1;
    sb_push(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    bus.i_addr = 32'h100;
    bus.i_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.i_ack !== 1'b0) begin
      failures++;
      $display("FAIL fetch_req_latency got mem_req=%b i_ack=%b exp mem_req=1 i_ack=0", bus.mem_req, bus.i_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h2402_0005 || bus.d_ack !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ack got i_ack=%b i_rdata=%h d_ack=%b exp i_ack=1 i_rdata=24020005 d_ack=0",
               bus.i_ack, bus.i_rdata, bus.d_ack);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.i_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ack_pulse got i_ack=%b mem_req=%b exp 0 0", bus.i_ack, bus.mem_req);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_d_write();
    mem_lat = 3;
    sb_push(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
    bus.d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_wstrb !== 4'hF || bus.d_ack !== 1'b0 || bus.i_ack !== 1'b0) begin
        failures++;
        $display("FAIL write_busy cycle=%0d got mem_req=%b mem_wstrb=%h d_ack=%b i_ack=%b exp 1 f 0 0",
                 k, bus.mem_req, bus.mem_wstrb, bus.d_ack, bus.i_ack);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL write_ack got d_ack=%b i_ack=%b mem_req=%b exp 1 0 0", bus.d_ack, bus.i_ack, bus.mem_req);
    end
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    int n_txn;
    int start;
    int i_start;
    int cyc;
    int exp_i;
`ifdef STARVE_GUARD_EN
    n_txn = 10;
    exp_i = 2;
    for (int k = 0; k < n_txn; k++) begin
      if (k % 5 == 4) sb_push(1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
      else            sb_push(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    end
`else
    n_txn = 20;
    exp_i = 0;
    for (int k = 0; k < n_txn; k++) sb_push(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
`endif
    mem_lat = 1;
    start   = ack_cnt;
    i_start = i_ack_cnt;
    bus.i_addr = 32'h200;
    bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_wdata = 32'h0; bus.d_wstrb = 4'hF;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    cyc = 0;
    while (ack_cnt - start < n_txn && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    checks++;
    if (ack_cnt - start != n_txn) begin
      failures++;
      $display("FAIL contention_timeout got acks=%0d exp acks=%0d", ack_cnt - start, n_txn);
    end
    checks++;
    if (i_ack_cnt - i_start != exp_i) begin
      failures++;
      $display("FAIL contention_i_acks got %0d exp %0d", i_ack_cnt - i_start, exp_i);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    mem_lat = 2;
    sb_push(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    sb_push(1'b0, 1'b0, 32'h104, 32'h0, 4'h0);
    bus.d_we = 1'b0; bus.d_addr = 32'h300;
    bus.i_addr = 32'h104;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.d_ack !== 1'b1 && cyc < 50);
    bus.d_req = 1'b0;
    checks++;
    if (bus.d_ack !== 1'b1 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_d_ack got d_ack=%b mem_req=%b exp 1 0", bus.d_ack, bus.mem_req);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      failures++;
      $display("FAIL b2b_turnaround got mem_req=%b d_ack=%b exp 0 0", bus.mem_req, bus.d_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104) begin
      failures++;
      $display("FAIL b2b_i_grant got mem_req=%b mem_addr=%h exp 1 00000104", bus.mem_req, bus.mem_addr);
    end
    cyc = 0;
    while (bus.i_ack !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    bus.i_req = 1'b0;
    checks++;
    if (bus.i_ack !== 1'b1) begin
      failures++;
      $display("FAIL b2b_i_ack got i_ack=%b exp 1", bus.i_ack);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    mem_lat = 4;
    sb_push(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 4'h3);
    bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'hCAFE_F00D; bus.d_wstrb = 4'h3;
    bus.d_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.mem_req !== 1'b1 && cyc < 20);
    @(negedge clk);
    reset = 1'b0;
    bus.d_req = 1'b0;
    pend_q.delete();
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got mem_req=%b d_ack=%b exp 0 0", bus.mem_req, bus.d_ack);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_auto = 1'b0;
    @(negedge clk);
    bus.mem_rdata = 32'hBAD0_BAD0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 ||
          bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
        failures++;
        $display("FAIL stray_ready cycle=%0d got mem_req=%b i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h exp all 0",
                 k, bus.mem_req, bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata);
      end
    end
    mem_auto = 1'b1;
    mem_lat  = 1;
    sb_push(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    bus.i_addr = 32'h100;
    bus.i_req  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.i_ack !== 1'b1 && cyc < 20);
    bus.i_req = 1'b0;
    checks++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h2402_0005 || cyc != 2) begin
      failures++;
      $display("FAIL post_reset_fetch got i_ack=%b i_rdata=%h latency=%0d exp 1 24020005 2",
               bus.i_ack, bus.i_rdata, cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;
    reset = 1'b0;
    test_reset();
    test_single_fetch();
    test_d_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got exp_q=%0d pend_q=%0d exp 0 0", exp_q.size(), pend_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
